// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the programmable clock divider.
// Holds the controller state enum, the divisor-legality rule and the high-phase length.
// Legality depends on compile macro CLK_DIV_CTRL_ODD_EN (odd divisors allowed when defined).
package clk_div_pkg;

  // Controller states: idle, running at the current ratio, running with a request queued.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Smallest divisor that still produces a distinct high and low phase.
  localparam int unsigned MIN_DIV = 2;

  // A divisor is usable if it is at least MIN_DIV; odd values only when the
  // odd-divisor build option is present, so the default build keeps 50% duty.
  function automatic logic div_legal(input int unsigned d);
`ifdef CLK_DIV_CTRL_ODD_EN
    return (d >= MIN_DIV);
`else
    return (d >= MIN_DIV) && (d[0] == 1'b0);
`endif
  endfunction

  // Number of high cycles per period: ceil(d/2). For odd d the extra cycle
  // goes to the high phase.
  function automatic int unsigned half_ceil(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter plus registered out_clk / tick generation.
// Latency: a load with run asserted shows cnt=0 and out_clk=1 on the next cycle.
// Backpressure: none; it follows i_load/i_run every cycle.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_run,
  output logic             o_out_clk,
  output logic             o_tick,
  output logic             o_period_end
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_div_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W:0]   w_half_n;
  logic             w_last;
  logic             w_out_clk_n;
  logic             w_tick_n;

  // Next counter/output values; outputs are derived from the next count so
  // the registered out_clk and tick always line up with the registered cnt.
  always_comb begin
    w_div_n     = i_load ? i_div : r_div;
    w_last      = (r_cnt == (r_div - ONE));
    w_half_n    = (CNT_W+1)'(half_ceil(32'(w_div_n)));
    w_cnt_n     = ZERO;
    w_out_clk_n = 1'b0;
    w_tick_n    = 1'b0;
    if (i_run) begin
      if (i_load || w_last) begin
        w_cnt_n = ZERO;
      end else begin
        w_cnt_n = r_cnt + ONE;
      end
      w_out_clk_n = ({1'b0, w_cnt_n} < w_half_n);
      w_tick_n    = (w_cnt_n == (w_div_n - ONE));
    end
  end

  // Divisor, counter and registered outputs; async clear back to the default ratio.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= CNT_W'(DEF_DIV);
      r_cnt     <= ZERO;
      r_out_clk <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_div     <= w_div_n;
      r_cnt     <= w_cnt_n;
      r_out_clk <= w_out_clk_n;
      r_tick    <= w_tick_n;
    end
  end

  assign o_out_clk    = r_out_clk;
  assign o_tick       = r_tick;
  // The registered tick marks the last cycle of the current period.
  assign o_period_end = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with glitch-free ratio/start/stop changes.
// Latency: STOP->RUN output at t+1; RUN changes land on the first cycle after the current tick; err at t+1.
// Backpressure: cfg_ready drops while a request is queued (PEND) until the period ends. Option: CLK_DIV_CTRL_ODD_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             out_clk,
  output logic             tick,
  output logic             busy,
  output logic             err
);

  state_e           r_state;
  state_e           w_state_n;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_en;
  logic             r_cfg_ready;
  logic             r_busy;
  logic             r_err;

  logic             w_xfer;
  logic             w_legal;
  logic             w_pend_ld;
  logic             w_core_load;
  logic [CNT_W-1:0] w_core_div;
  logic             w_core_run;
  logic             w_err_n;
  logic             w_period_end;

  assign w_xfer  = cfg_valid && r_cfg_ready;
  assign w_legal = div_legal(32'(cfg_div));

  // Next state and core controls. Illegal requests are consumed but only raise err.
  always_comb begin
    w_state_n   = r_state;
    w_pend_ld   = 1'b0;
    w_core_load = 1'b0;
    w_core_div  = cfg_div;
    w_err_n     = w_xfer && !w_legal;
    case (r_state)
      ST_STOP: begin
        // Divisor is taken immediately; only cfg_en decides whether to start.
        if (w_xfer && w_legal) begin
          w_core_load = 1'b1;
          w_core_div  = cfg_div;
          if (cfg_en) begin
            w_state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Queue the request; a transfer on a tick cycle still waits a full period
        // because the period end is only acted on from PEND.
        if (w_xfer && w_legal) begin
          w_pend_ld = 1'b1;
          w_state_n = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_period_end) begin
          if (r_pend_en) begin
            w_core_load = 1'b1;
            w_core_div  = r_pend_div;
            w_state_n   = ST_RUN;
          end else begin
            w_state_n = ST_STOP;
          end
        end
      end
      default: begin
        w_state_n = ST_STOP;
      end
    endcase
    w_core_run = (w_state_n != ST_STOP);
  end

  // State, queued request and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_STOP;
      r_pend_div  <= CNT_W'(DEF_DIV);
      r_pend_en   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      if (w_pend_ld) begin
        r_pend_div <= cfg_div;
        r_pend_en  <= cfg_en;
      end
      r_cfg_ready <= (w_state_n != ST_PEND);
      r_busy      <= (w_state_n != ST_STOP);
      r_err       <= w_err_n;
    end
  end

  clk_div_core #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_core_load),
    .i_div        (w_core_div),
    .i_run        (w_core_run),
    .o_out_clk    (out_clk),
    .o_tick       (tick),
    .o_period_end (w_period_end)
  );

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: drives and samples 1 time unit after each rising edge.
module tb_clk_div_ctrl;

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       out_clk;
  logic       tick;
  logic       busy;
  logic       err;

  int checks;
  int errors;

  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .out_clk   (out_clk),
    .tick      (tick),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;
    step;
    step;
    reset = 1'b1;
    step;
  endtask

  // One-cycle request; returns at the sample point of cycle t+1.
  task automatic send(input logic [7:0] d, input logic en);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cfg_en    = en;
    step;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (out_clk !== 1'b0)   begin errors++; $display("FAIL reset_out_clk got %b want 0", out_clk); end
    checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_basic_run;
    logic [7:0] exp_out;
    logic [7:0] exp_tick;
    exp_out  = 8'b1100_1100;
    exp_tick = 8'b0001_0001;
    do_reset;
    send(8'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_clk !== exp_out[7-i])  begin errors++; $display("FAIL basic_out[%0d] got %b want %b", i, out_clk, exp_out[7-i]); end
      checks++; if (tick !== exp_tick[7-i])    begin errors++; $display("FAIL basic_tick[%0d] got %b want %b", i, tick, exp_tick[7-i]); end
      checks++; if (busy !== 1'b1)             begin errors++; $display("FAIL basic_busy[%0d] got %b want 1", i, busy); end
      step;
    end
  endtask

  task automatic test_ratio_change;
    logic [5:0] exp_out;
    logic [5:0] exp_tick;
    exp_out  = 6'b111000;
    exp_tick = 6'b000001;
    do_reset;
    send(8'd4, 1'b1);   // cnt0
    step;               // cnt1
    send(8'd6, 1'b1);   // cnt2, queued
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ratio_ready_c2 got %b want 0", cfg_ready); end
    checks++; if (out_clk !== 1'b0)   begin errors++; $display("FAIL ratio_out_c2 got %b want 0", out_clk); end
    step;               // cnt3, tick
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ratio_ready_c3 got %b want 0", cfg_ready); end
    checks++; if (tick !== 1'b1)      begin errors++; $display("FAIL ratio_tick_c3 got %b want 1", tick); end
    step;               // new period, D=6
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_clk !== exp_out[5-i]) begin errors++; $display("FAIL ratio_out[%0d] got %b want %b", i, out_clk, exp_out[5-i]); end
      checks++; if (tick !== exp_tick[5-i])   begin errors++; $display("FAIL ratio_tick[%0d] got %b want %b", i, tick, exp_tick[5-i]); end
      checks++; if (cfg_ready !== 1'b1)       begin errors++; $display("FAIL ratio_ready[%0d] got %b want 1", i, cfg_ready); end
      step;
    end
  endtask

  task automatic test_illegal;
    do_reset;
    send(8'd1, 1'b1);   // from STOP
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL ill_stop_err got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_stop_busy got %b want 0", busy); end
    step;
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL ill_stop_err_clr got %b want 0", err); end
    send(8'd4, 1'b1);   // cnt0
    send(8'd0, 1'b1);   // cnt1
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL ill_d0_err got %b want 1", err); end
    checks++; if (out_clk !== 1'b1)   begin errors++; $display("FAIL ill_d0_out got %b want 1", out_clk); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ill_d0_ready got %b want 1", cfg_ready); end
    step;               // cnt2
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL ill_d0_err_clr got %b want 0", err); end
    checks++; if (out_clk !== 1'b0)   begin errors++; $display("FAIL ill_d0_out_c2 got %b want 0", out_clk); end
    send(8'd1, 1'b1);   // cnt3
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL ill_d1_err got %b want 1", err); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL ill_d1_tick got %b want 1", tick); end
    step;               // cnt0 still D=4
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL ill_d1_err_clr got %b want 0", err); end
    checks++; if (out_clk !== 1'b1) begin errors++; $display("FAIL ill_d1_out_c0 got %b want 1", out_clk); end
  endtask

  task automatic test_odd;
`ifdef CLK_DIV_CTRL_ODD_EN
    logic [4:0] exp_out;
    logic [4:0] exp_tick;
    exp_out  = 5'b11100;
    exp_tick = 5'b00001;
`else
    logic [3:0] exp_out;
    exp_out = 4'b1100;
`endif
    do_reset;
    send(8'd4, 1'b1);   // cnt0
    send(8'd5, 1'b1);   // cnt1
`ifdef CLK_DIV_CTRL_ODD_EN
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL odd_err got %b want 0", err); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL odd_ready got %b want 0", cfg_ready); end
    step; step; step;   // cnt2, cnt3, then D=5 cnt0
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_clk !== exp_out[4-i]) begin errors++; $display("FAIL odd_out[%0d] got %b want %b", i, out_clk, exp_out[4-i]); end
      checks++; if (tick !== exp_tick[4-i])   begin errors++; $display("FAIL odd_tick[%0d] got %b want %b", i, tick, exp_tick[4-i]); end
      step;
    end
`else
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL odd_err got %b want 1", err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL odd_ready got %b want 1", cfg_ready); end
    step;
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL odd_err_clr got %b want 0", err); end
    step; step;         // cnt0 of unchanged D=4
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_clk !== exp_out[3-i]) begin errors++; $display("FAIL odd_keep_out[%0d] got %b want %b", i, out_clk, exp_out[3-i]); end
      step;
    end
`endif
  endtask

  task automatic test_stop;
    do_reset;
    send(8'd4, 1'b1);   // cnt0
    send(8'd4, 1'b0);   // cnt1
    checks++; if (out_clk !== 1'b1)   begin errors++; $display("FAIL stop_out_c1 got %b want 1", out_clk); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stop_ready_c1 got %b want 0", cfg_ready); end
    step; step;         // cnt3
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL stop_tick_c3 got %b want 1", tick); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_c3 got %b want 1", busy); end
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (out_clk !== 1'b0)   begin errors++; $display("FAIL stop_out[%0d] got %b want 0", i, out_clk); end
      checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL stop_tick[%0d] got %b want 0", i, tick); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL stop_busy[%0d] got %b want 0", i, busy); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready[%0d] got %b want 1", i, cfg_ready); end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_out;
    logic [9:0] exp_tick;
    logic [9:0] exp_rdy;
    exp_out  = 10'b1100_111000;
    exp_tick = 10'b0001_000001;
    exp_rdy  = 10'b0000_111111;
    do_reset;
    send(8'd4, 1'b1);   // cnt0
    step; step; step;   // cnt3, tick
    send(8'd6, 1'b1);   // transfer on the tick cycle
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_clk !== exp_out[9-i])  begin errors++; $display("FAIL bnd_out[%0d] got %b want %b", i, out_clk, exp_out[9-i]); end
      checks++; if (tick !== exp_tick[9-i])    begin errors++; $display("FAIL bnd_tick[%0d] got %b want %b", i, tick, exp_tick[9-i]); end
      checks++; if (cfg_ready !== exp_rdy[9-i]) begin errors++; $display("FAIL bnd_ready[%0d] got %b want %b", i, cfg_ready, exp_rdy[9-i]); end
      step;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_out;
    exp_out = 8'b1100_1100;
    do_reset;
    send(8'd6, 1'b1);   // cnt0
    step;               // cnt1
    checks++; if (out_clk !== 1'b1) begin errors++; $display("FAIL rmid_pre_out got %b want 1", out_clk); end
    reset = 1'b0;
    #1;
    checks++; if (out_clk !== 1'b0)   begin errors++; $display("FAIL rmid_out got %b want 0", out_clk); end
    checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL rmid_tick got %b want 0", tick); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rmid_err got %b want 0", err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", cfg_ready); end
    step;
    reset = 1'b1;
    step;
    send(8'd4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_clk !== exp_out[7-i]) begin errors++; $display("FAIL rmid_restart_out[%0d] got %b want %b", i, out_clk, exp_out[7-i]); end
      step;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;
    test_reset;
    test_basic_run;
    test_ratio_change;
    test_illegal;
    test_odd;
    test_stop;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller: generates a divided clock `out_clk` and a one-cycle `tick` strobe from `clk` under a valid/ready configuration handshake. Divisor changes and start/stop requests take effect only on a period boundary, so `out_clk` never shows a runt pulse. It sits between software/control logic and the divided-clock consumers, replacing free-running fixed-ratio dividers wherever the ratio must change at runtime.

## Interface

Parameters:

- `CNT_W`, 8 — divisor/counter width.
- `DEF_DIV`, 4 — divisor loaded at reset. Must be legal (see Operation).

Ports:

- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `cfg_valid` in 1 — configuration request.
- `cfg_ready` out 1 — controller can accept a request.
- `cfg_div` in CNT_W — requested divisor D.
- `cfg_en` in 1 — 1 = run, 0 = stop.
- `out_clk` out 1 — divided clock, registered.
- `tick` out 1 — high in the last `clk` cycle of each `out_clk` period.
- `busy` out 1 — state is not STOP.
- `err` out 1 — one-cycle pulse when a request is rejected.

## Operation

- **FSM states:** STOP, RUN, PEND.
- **Reset values:** state = STOP, divisor = `DEF_DIV`, cnt = 0, `out_clk` = 0, `tick` = 0, `cfg_ready` = 1, `busy` = 0, `err` = 0.
- **Transfer:** a transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready` = 0 only in PEND.
- **Legal divisor:** D ≥ 2, and D must be even unless the odd-divisor feature is compiled in (see Configuration).
- **Illegal divisor:** the transfer is still accepted. `err` = 1 on the next cycle, and the request is discarded. State, divisor and counter are unchanged.
- **Period generation (RUN and PEND):**
  - cnt runs 0..D−1 and wraps to 0.
  - `out_clk` = 1 while cnt < H, where H = ceil(D/2); otherwise 0.
  - `tick` = 1 when cnt = D−1.
- **STOP + legal transfer:**
  - The divisor is loaded immediately.
  - If `cfg_en` = 1, go to RUN with cnt = 0.
  - If `cfg_en` = 0, stay in STOP; the new divisor is stored for later.
- **RUN + legal transfer:**
  - Latch {D, en} into the pending registers and go to PEND.
  - At the next period end (cnt = D−1), apply the pending request:
    - en = 1: load the new D, cnt → 0, go to RUN.
    - en = 0: go to STOP; `out_clk` = 0 and `tick` = 0 from the following cycle.
- **Transfer on the same cycle as a period end while in RUN:** the request applies at the end of the *next* period, not the current one.
- **Requests in PEND:** not possible, because `cfg_ready` = 0. `cfg_valid` is simply held by the requester.
- **Reset mid-operation:** all registers return to their reset values asynchronously. After release the block is in STOP with D = `DEF_DIV`.
- **Counter width:** cnt and the divisor are CNT_W bits. The maximum divisor is 2^CNT_W − 1, which requires the odd-divisor feature; otherwise the largest legal divisor is 2^CNT_W − 2.

## Timing

- **Start latency:** transfer at cycle t in STOP gives `out_clk` = 1 at t+1, with cnt = 0 at t+1.
- **Ratio change:** new D is effective on the first cycle after the current period's `tick`.
- **cfg_ready low window:** from t+1 through the `tick` cycle; `cfg_ready` = 1 again on the following cycle.
- **Error latency:** `err` asserts at t+1 for exactly one cycle.
- **Output registration:** all outputs are registered; there is no combinational path from `cfg_*` to outputs.

## Configuration

- **Macro:** `CLK_DIV_CTRL_ODD_EN`.
- **Defined:** odd D ≥ 3 is legal. `out_clk` is high for (D+1)/2 cycles and low for (D−1)/2 cycles.
- **Undefined:** odd D is illegal and produces an `err` pulse. Duty cycle is always exactly 50%.

## Structure

- **Package `clk_div_pkg`:** state enum (STOP/RUN/PEND) and a divisor-legality function parameterised by the macro.
- **Sub-module `clk_div_core`:** counter, `out_clk` and `tick` generation. Inputs are load/enable/divisor; output includes a period-end flag.
- **Top `clk_div_ctrl`:** FSM, pending registers, handshake and `err` generation.

## Test plan

- **Basic run:** reset, then D=4, en=1 from STOP → `out_clk` 1,1,0,0 repeating; `tick` on every 4th cycle; `busy` = 1.
- **Ratio change:** RUN at D=4, send D=6 at cnt=1 → `cfg_ready` low until the `tick`; the next period is 3 high, 3 low.
- **Illegal divisors:**
  - D=0 or D=1 → `err` pulse at t+1; D=4 output unaffected.
  - D=5 without the macro → `err` pulse.
  - D=5 with the macro → 3 high, 2 low.
- **Stop:** en=0 in RUN at cnt=0 → the current period completes, then `out_clk` = 0 and `busy` = 0, state STOP.
- **Boundary transfer:** transfer on the `tick` cycle → one more old-D period runs before the new D applies.
- **Reset mid-period:** assert reset at cnt=1 → all outputs 0 and `cfg_ready` = 1 immediately. After release, en=1 with D=`DEF_DIV` restarts cleanly.
